// File: rtl/dram_responder_model.sv
// -----------------------------------------------------------------------------
// dram_responder_model
//
// Synthesizable stand-in for the DDR3 controller on the responder side of the
// memrequest interface. Requests are serviced from an on-chip RAM and complete
// in order after a fixed latency. A busy throttle (a gap after each accept plus
// periodic refresh windows) mimics the pacing of the real controller.
//
// Ports:
//   clk_dram_ctrl            sole clock
//   rst_dram_ctrl_n          asynchronous active-low reset
//   memrequest_addr          request word address (low bits index the RAM)
//   memrequest_en            request strobe, held by initiator until accepted
//   memrequest_write_data    write payload
//   memrequest_write_enable  1 = write, 0 = read
//   memrequest_resp_data     read data, qualified by memrequest_complete
//   memrequest_complete      one-cycle completion pulse, one per accept
//   memrequest_busy          request not accepted this cycle
//   outstanding_count        accepted requests not yet completed
// -----------------------------------------------------------------------------
module dram_responder_model #(
    parameter int ADDR_WIDTH       = 24,
    parameter int DATA_WIDTH       = 128,
    parameter int DEPTH            = 4096,
    parameter int READ_LATENCY     = 6,
    parameter int ISSUE_GAP        = 2,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int REFRESH_CYCLES   = 16
) (
    input  logic                  clk_dram_ctrl,
    input  logic                  rst_dram_ctrl_n,
    input  logic [ADDR_WIDTH-1:0] memrequest_addr,
    input  logic                  memrequest_en,
    input  logic [DATA_WIDTH-1:0] memrequest_write_data,
    input  logic                  memrequest_write_enable,
    output logic [DATA_WIDTH-1:0] memrequest_resp_data,
    output logic                  memrequest_complete,
    output logic                  memrequest_busy,
    output logic [5:0]            outstanding_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam int RFT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int RFC_W = $clog2(REFRESH_CYCLES + 1);

    localparam bit               REFRESH_EN = (REFRESH_INTERVAL > 0);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(ISSUE_GAP);
    localparam logic [RFT_W-1:0] RFT_LAST   = RFT_W'((REFRESH_INTERVAL > 0) ? REFRESH_INTERVAL - 1 : 0);
    localparam logic [RFC_W-1:0] RFC_LOAD   = RFC_W'(REFRESH_CYCLES);

    // Upper address bits are ignored on purpose: addresses alias modulo DEPTH.
    logic [IDX_W-1:0] idx;
    assign idx = memrequest_addr[IDX_W-1:0];

    generate
        if (ADDR_WIDTH > IDX_W) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = ^memrequest_addr[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    logic accept;
    assign accept = memrequest_en & ~memrequest_busy;

    // Busy bookkeeping. Both counters hold the number of busy cycles still owed,
    // including the current one, so busy(t+1) is simply "either next count != 0".
    logic [GAP_W-1:0] gap_cnt, gap_next;
    logic [RFT_W-1:0] ref_timer;
    logic [RFC_W-1:0] ref_cnt, ref_next;
    logic             ref_start;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        gap_next  = gap_cnt;
        ref_next  = ref_cnt;
        ref_start = REFRESH_EN && (ref_timer == RFT_LAST);

        if (accept) begin
            gap_next = GAP_LOAD;
        end else if (gap_cnt != '0) begin
            gap_next = gap_cnt - GAP_W'(1);
        end

        // A refresh start reloads the window; gap and refresh only OR together.
        if (ref_start) begin
            ref_next = RFC_LOAD;
        end else if (ref_cnt != '0) begin
            ref_next = ref_cnt - RFC_W'(1);
        end
    end

    // Latency pipeline: stage i holds a request accepted i+1 cycles ago, so the
    // last stage is valid exactly READ_LATENCY cycles after the accept.
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_write;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   resp_hold;
    logic [DATA_WIDTH-1:0]   comp_data;

    assign memrequest_complete = pipe_valid[READ_LATENCY-1];
    assign comp_data           = pipe_write[READ_LATENCY-1] ? '0 : pipe_data[READ_LATENCY-1];
    // Present new data in the completion cycle, otherwise hold the last response.
    assign memrequest_resp_data = memrequest_complete ? comp_data : resp_hold;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its sources regardless of statement order.
    always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
        if (!rst_dram_ctrl_n) begin
            memrequest_busy   <= 1'b1;
            outstanding_count <= '0;
            gap_cnt           <= '0;
            ref_timer         <= '0;
            ref_cnt           <= '0;
            pipe_valid        <= '0;
            pipe_write        <= '0;
            resp_hold         <= '0;
        end else begin
            memrequest_busy <= (gap_next != '0) || (ref_next != '0);
            gap_cnt         <= gap_next;
            ref_cnt         <= ref_next;

            if (REFRESH_EN) begin
                ref_timer <= ref_start ? '0 : ref_timer + RFT_W'(1);
            end

            pipe_valid <= {pipe_valid[READ_LATENCY-2:0], accept};
            pipe_write <= {pipe_write[READ_LATENCY-2:0], memrequest_write_enable};

            if (memrequest_complete) begin
                resp_hold <= comp_data;
            end

            case ({accept, memrequest_complete})
                2'b10:   outstanding_count <= outstanding_count + 6'd1;
                2'b01:   outstanding_count <= outstanding_count - 6'd1;
                default: outstanding_count <= outstanding_count;
            endcase
        end
    end

    // NOTE: the RAM and the data lanes of the pipeline carry no reset; contents
    // survive a reset and the valid bits alone decide what is observed.
    logic [DATA_WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk_dram_ctrl) begin
        if (accept && memrequest_write_enable) begin
            ram[idx] <= memrequest_write_data;
        end
        // Sampled at the accept edge, so a read sees the contents before any
        // write landing on the same edge.
        pipe_data[0] <= ram[idx];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

endmodule

// File: tb/tb_dram_responder_model.sv
// -----------------------------------------------------------------------------
// tb_dram_responder_model
//
// Directed bench for dram_responder_model. Three instances share one clock:
//   u_b2b : ISSUE_GAP=0, refresh off  (back-to-back traffic, mid-flight reset)
//   u_dut : default parameters        (gap throttle, aliasing / read-after-write)
//   u_ref : REFRESH_INTERVAL=64       (refresh stall, completions during stall)
// Inputs are driven and outputs sampled on the falling edge; the value seen at
// the falling edge of cycle t is the DUT state for cycle t.
// -----------------------------------------------------------------------------
module tb_dram_responder_model;

    logic clk_dram_ctrl = 1'b0;
    always #5 clk_dram_ctrl = ~clk_dram_ctrl;

    int n_cmp;
    int n_mis;

    // u_b2b signals
    logic         b2b_rst_n, b2b_en, b2b_we;
    logic [23:0]  b2b_addr;
    logic [127:0] b2b_wdata, b2b_resp;
    logic         b2b_comp, b2b_busy;
    logic [5:0]   b2b_outs;

    // u_dut signals
    logic         gap_rst_n, gap_en, gap_we;
    logic [23:0]  gap_addr;
    logic [127:0] gap_wdata, gap_resp;
    logic         gap_comp, gap_busy;
    logic [5:0]   gap_outs;

    // u_ref signals
    logic         ref_rst_n, ref_en, ref_we;
    logic [23:0]  ref_addr;
    logic [127:0] ref_wdata, ref_resp;
    logic         ref_comp, ref_busy;
    logic [5:0]   ref_outs;

    dram_responder_model #(.ISSUE_GAP(0), .REFRESH_INTERVAL(0)) u_b2b (
        .clk_dram_ctrl          (clk_dram_ctrl),
        .rst_dram_ctrl_n        (b2b_rst_n),
        .memrequest_addr        (b2b_addr),
        .memrequest_en          (b2b_en),
        .memrequest_write_data  (b2b_wdata),
        .memrequest_write_enable(b2b_we),
        .memrequest_resp_data   (b2b_resp),
        .memrequest_complete    (b2b_comp),
        .memrequest_busy        (b2b_busy),
        .outstanding_count      (b2b_outs)
    );

    dram_responder_model u_dut (
        .clk_dram_ctrl          (clk_dram_ctrl),
        .rst_dram_ctrl_n        (gap_rst_n),
        .memrequest_addr        (gap_addr),
        .memrequest_en          (gap_en),
        .memrequest_write_data  (gap_wdata),
        .memrequest_write_enable(gap_we),
        .memrequest_resp_data   (gap_resp),
        .memrequest_complete    (gap_comp),
        .memrequest_busy        (gap_busy),
        .outstanding_count      (gap_outs)
    );

    dram_responder_model #(.REFRESH_INTERVAL(64), .REFRESH_CYCLES(16)) u_ref (
        .clk_dram_ctrl          (clk_dram_ctrl),
        .rst_dram_ctrl_n        (ref_rst_n),
        .memrequest_addr        (ref_addr),
        .memrequest_en          (ref_en),
        .memrequest_write_data  (ref_wdata),
        .memrequest_write_enable(ref_we),
        .memrequest_resp_data   (ref_resp),
        .memrequest_complete    (ref_comp),
        .memrequest_busy        (ref_busy),
        .outstanding_count      (ref_outs)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int       exp_outs;
        int       peak;
        int       last_acc;
        int       acc_cnt;
        int       cmp_cnt;
        bit       busy_e;
        bit [0:127] exp_comp;

        n_cmp = 0;
        n_mis = 0;
        b2b_rst_n = 1'b0; b2b_en = 1'b0; b2b_we = 1'b0; b2b_addr = '0; b2b_wdata = '0;
        gap_rst_n = 1'b0; gap_en = 1'b0; gap_we = 1'b0; gap_addr = '0; gap_wdata = '0;
        ref_rst_n = 1'b0; ref_en = 1'b0; ref_we = 1'b0; ref_addr = '0; ref_wdata = '0;

        repeat (3) @(negedge clk_dram_ctrl);

        // ---------------- reset values ----------------
        check("rst busy",     128'(b2b_busy), 128'd1);
        check("rst complete", 128'(b2b_comp), 128'd0);
        check("rst resp",     b2b_resp,       128'd0);
        check("rst outs",     128'(b2b_outs), 128'd0);
        check("rst busy dut", 128'(gap_busy), 128'd1);
        check("rst busy ref", 128'(ref_busy), 128'd1);

        // ---------------- back-to-back (u_b2b) ----------------
        b2b_rst_n = 1'b1;
        @(negedge clk_dram_ctrl);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("b2b busy c%0d", k), 128'(b2b_busy), 128'd0);
            check($sformatf("b2b complete c%0d", k), 128'(b2b_comp),
                  128'((k >= 6 && k < 14) ? 1 : 0));
            if (k >= 6 && k < 10)
                check($sformatf("b2b wr resp c%0d", k), b2b_resp, 128'd0);
            if (k >= 10 && k < 14)
                check($sformatf("b2b rd resp c%0d", k), b2b_resp, 128'(160 + k - 10));
            exp_outs = ((k < 8) ? k : 8) - (((k < 14) ? k : 14) > 6 ? ((k < 14) ? k : 14) - 6 : 0);
            check($sformatf("b2b outs c%0d", k), 128'(b2b_outs), 128'(exp_outs));
            b2b_en    = (k < 8);
            b2b_we    = (k < 4);
            b2b_addr  = 24'(k % 4);
            b2b_wdata = 128'(160 + k);
            @(negedge clk_dram_ctrl);
        end
        check("b2b resp hold",  b2b_resp,       128'hA3);
        check("b2b idle comp",  128'(b2b_comp), 128'd0);
        check("b2b drained",    128'(b2b_outs), 128'd0);

        // ---------------- mid-flight reset (u_b2b) ----------------
        for (int r = 0; r < 3; r++) begin
            b2b_en   = 1'b1;
            b2b_we   = 1'b0;
            b2b_addr = 24'(r + 1);
            @(negedge clk_dram_ctrl);
        end
        check("mid outs before rst", 128'(b2b_outs), 128'd3);
        b2b_en    = 1'b0;
        b2b_rst_n = 1'b0;
        #1;
        check("mid rst busy", 128'(b2b_busy), 128'd1);
        check("mid rst outs", 128'(b2b_outs), 128'd0);
        for (int r = 0; r < 10; r++) begin
            @(negedge clk_dram_ctrl);
            check($sformatf("mid complete r%0d", r), 128'(b2b_comp), 128'd0);
            check($sformatf("mid busy r%0d", r),     128'(b2b_busy), 128'd1);
            check($sformatf("mid outs r%0d", r),     128'(b2b_outs), 128'd0);
        end
        check("mid rst resp", b2b_resp, 128'd0);
        b2b_rst_n = 1'b1;
        @(negedge clk_dram_ctrl);
        check("mid release busy", 128'(b2b_busy), 128'd0);
        b2b_en   = 1'b1;
        b2b_we   = 1'b0;
        b2b_addr = 24'd0;
        @(negedge clk_dram_ctrl);
        b2b_en = 1'b0;
        repeat (5) @(negedge clk_dram_ctrl);
        check("mid retained complete", 128'(b2b_comp), 128'd1);
        check("mid retained data",     b2b_resp,       128'hA0);

        // ---------------- gap throttle (u_dut) ----------------
        gap_rst_n = 1'b1;
        @(negedge clk_dram_ctrl);
        gap_en    = 1'b1;
        gap_we    = 1'b1;
        gap_addr  = 24'h10;
        gap_wdata = 128'h55;
        peak      = 0;
        for (int j = 0; j < 21; j++) begin
            check($sformatf("gap busy j%0d", j), 128'(gap_busy), 128'((j % 3 != 0) ? 1 : 0));
            check($sformatf("gap complete j%0d", j), 128'(gap_comp),
                  128'((j >= 6 && j % 3 == 0) ? 1 : 0));
            if (j >= 6 && j % 3 == 0)
                check($sformatf("gap resp j%0d", j), gap_resp, 128'd0);
            exp_outs = (j + 2) / 3 - ((j >= 7) ? (j - 7) / 3 + 1 : 0);
            check($sformatf("gap outs j%0d", j), 128'(gap_outs), 128'(exp_outs));
            if (int'(gap_outs) > peak) peak = int'(gap_outs);
            @(negedge clk_dram_ctrl);
        end
        gap_en = 1'b0;
        check("gap outs peak", 128'(peak), 128'd2);
        repeat (7) @(negedge clk_dram_ctrl);
        check("gap drained", 128'(gap_outs), 128'd0);

        // ---------------- aliasing / read-after-write (u_dut) ----------------
        check("raw busy w", 128'(gap_busy), 128'd0);
        gap_en    = 1'b1;
        gap_we    = 1'b1;
        gap_addr  = 24'h001005;
        gap_wdata = 128'h1234;
        @(negedge clk_dram_ctrl);                     // w+1
        check("raw busy w+1", 128'(gap_busy), 128'd1);
        gap_we   = 1'b0;
        gap_addr = 24'h000005;
        @(negedge clk_dram_ctrl);                     // w+2
        check("raw busy w+2", 128'(gap_busy), 128'd1);
        @(negedge clk_dram_ctrl);                     // w+3, read accepted
        check("raw busy w+3", 128'(gap_busy), 128'd0);
        @(negedge clk_dram_ctrl);                     // w+4
        gap_en = 1'b0;
        check("raw busy w+4", 128'(gap_busy), 128'd1);
        repeat (2) @(negedge clk_dram_ctrl);          // w+6
        check("raw wr complete", 128'(gap_comp), 128'd1);
        check("raw wr resp",     gap_resp,       128'd0);
        @(negedge clk_dram_ctrl);                     // w+7
        check("raw gap complete", 128'(gap_comp), 128'd0);
        repeat (2) @(negedge clk_dram_ctrl);          // w+9
        check("raw rd complete", 128'(gap_comp), 128'd1);
        check("raw rd resp",     gap_resp,       128'h1234);
        check("raw rd outs",     128'(gap_outs), 128'd1);
        @(negedge clk_dram_ctrl);                     // w+10
        check("raw resp hold",   gap_resp,       128'h1234);
        check("raw outs idle",   128'(gap_outs), 128'd0);

        // ---------------- refresh stall (u_ref) ----------------
        ref_rst_n = 1'b1;
        ref_en    = 1'b1;
        ref_we    = 1'b1;
        ref_addr  = 24'h7;
        ref_wdata = 128'h77;
        exp_comp  = '0;
        last_acc  = -100;
        acc_cnt   = 0;
        cmp_cnt   = 0;
        for (int c = 0; c < 100; c++) begin
            busy_e = (c == 0) || (c > last_acc && c - last_acc <= 2) ||
                     (c >= 64 && (c % 64) < 16);
            check($sformatf("ref busy c%0d", c),     128'(ref_busy), 128'(busy_e));
            check($sformatf("ref complete c%0d", c), 128'(ref_comp), 128'(exp_comp[c]));
            check($sformatf("ref outs c%0d", c),     128'(ref_outs), 128'(acc_cnt - cmp_cnt));
            if (exp_comp[c]) cmp_cnt++;
            if (!busy_e) begin
                last_acc         = c;
                exp_comp[c + 6]  = 1'b1;
                acc_cnt++;
            end
            @(negedge clk_dram_ctrl);
        end
        ref_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
